gray_conv_arbiter: RTL

//  Shares one binary-to-Gray conversion stage among N_REQ requesters. Each requester

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_encode.sv | 20 ++
 rtl/gray_conv_arbiter.sv | 69 ++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-conversion arbiter: default sizes, the
// binary-to-Gray helper and the round-robin search used by the arbiter.
package gray_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_REQ       = 32;

    function automatic logic [DEFAULT_WIDTH-1:0] bin2gray(input logic [DEFAULT_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Returns the first set index of valid[0 +: n] searching upward from ptr
    // with wrap, or -1 when nothing is set. Lower search offsets win.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int idx;
        rr_pick = -1;
        idx     = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (valid[idx[4:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder; the single conversion resource
// shared by all requesters.
module gray_encode
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    generate
        if (WIDTH == DEFAULT_WIDTH) begin : g_default
            assign gray = bin2gray(bin);
        end else begin : g_generic
            assign gray = bin ^ (bin >> 1);
        end
    endgenerate

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter in front of a shared Gray encoder with a one-deep
// registered response slot that can drain and refill in the same cycle.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_bin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_gray,
    output logic [WIDTH-1:0]       rsp_bin,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            grant_cnt
);

    logic [ID_W-1:0]  rr_ptr;
    logic             slot_free;
    logic             grant;
    int               pick;
    logic [ID_W-1:0]  grant_id;
    logic [WIDTH-1:0] grant_bin;
    logic [WIDTH-1:0] grant_gray;

    assign slot_free = !rsp_valid || rsp_ready;

    // Gating with rst_n keeps req_ready low while the block is held in reset.
    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), int'(rr_ptr), N_REQ);
        grant     = rst_n && slot_free && (pick >= 0);
        grant_id  = grant ? pick[ID_W-1:0] : '0;
        req_ready = '0;
        if (grant) req_ready[grant_id] = 1'b1;
    end

    assign grant_bin = req_bin[int'(grant_id)*WIDTH +: WIDTH];

    gray_encode #(.WIDTH(WIDTH)) u_encode (
        .bin  (grant_bin),
        .gray (grant_gray)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_gray  <= '0;
            rsp_bin   <= '0;
            rsp_id    <= '0;
            grant_cnt <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_gray  <= grant_gray;
            rsp_bin   <= grant_bin;
            rsp_id    <= grant_id;
            rr_ptr    <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            grant_cnt <= grant_cnt + 16'd1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
